// File: rtl/nexus_mult_pkg.sv
`default_nettype none
// ============================================================================
// nexus_mult_pkg
//   Shared widths, register-mode constants and operand extension helper for
//   the Nexus MULT9X9 behavioural model.
//   Revision: 1.0
// ============================================================================
package nexus_mult_pkg;

  localparam int MULT_A_W = 9;
  localparam int MULT_B_W = 9;
  localparam int MULT_Z_W = 18;

  // Mode strings are carried as 64-bit packed values so they compare cleanly
  // at elaboration time.
  localparam logic [63:0] MODE_BYPASS   = "BYPASS";
  localparam logic [63:0] MODE_REGISTER = "REGISTER";

  function automatic logic [MULT_Z_W-1:0] ext_operand(input logic [MULT_A_W-1:0] op,
                                                      input bit sgn);
    if (sgn)
      return {{(MULT_Z_W-MULT_A_W){op[MULT_A_W-1]}}, op};
    else
      return {{(MULT_Z_W-MULT_A_W){1'b0}}, op};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nexus_mult9x9_pipe_if.sv
`default_nettype none
// ============================================================================
// nexus_mult9x9_pipe_if
//   Operand/product bundle of the MULT9X9 model. AQ/BQ exist only when
//   NEXUS_MULT_TAP_EN is defined.
//   Revision: 1.0
// ============================================================================
interface nexus_mult9x9_pipe_if;
  import nexus_mult_pkg::*;

  logic                CEA;
  logic                CEB;
  logic                CEOUT;
  logic [MULT_A_W-1:0] A;
  logic [MULT_B_W-1:0] B;
  logic                VLD_I;
  logic [MULT_Z_W-1:0] Z;
  logic                VLD_O;
`ifdef NEXUS_MULT_TAP_EN
  logic [MULT_A_W-1:0] AQ;
  logic [MULT_B_W-1:0] BQ;
`endif

  modport master (
    output CEA, CEB, CEOUT, A, B, VLD_I,
    input  Z, VLD_O
`ifdef NEXUS_MULT_TAP_EN
    , input AQ, BQ
`endif
  );

  modport slave (
    input  CEA, CEB, CEOUT, A, B, VLD_I,
    output Z, VLD_O
`ifdef NEXUS_MULT_TAP_EN
    , output AQ, BQ
`endif
  );

endinterface
`default_nettype wire

// File: rtl/nexus_mult_stage.sv
`default_nettype none
// ============================================================================
// nexus_mult_stage
//   Width-parameterised enable register with async active-high reset, or a
//   plain wire when BYPASS is set.
//   Revision: 1.0
// ============================================================================
module nexus_mult_stage #(
  parameter int W      = 1,
  parameter bit BYPASS = 1'b0
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  input  wire logic         i_en,
  input  wire logic [W-1:0] i_d,
  output logic      [W-1:0] o_q
);

  generate
    if (BYPASS) begin : g_bypass
      logic w_unused;
      assign w_unused = &{1'b0, CLK, RST, i_en};
      assign o_q = i_d;
    end else begin : g_reg
      logic [W-1:0] r_q;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)
          r_q <= '0;
        else if (i_en)
          r_q <= i_d;
      end
      assign o_q = r_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/nexus_mult9x9_pipe.sv
`default_nettype none
// ============================================================================
// nexus_mult9x9_pipe
//   9x9 multiplier with optional A/B input and Z output registers plus a
//   tracking valid bit. Optional operand taps: NEXUS_MULT_TAP_EN.
//   Revision: 1.0
// ============================================================================
module nexus_mult9x9_pipe
  import nexus_mult_pkg::*;
#(
  parameter logic [63:0] REGINPUTA = MODE_BYPASS,
  parameter logic [63:0] REGINPUTB = MODE_BYPASS,
  parameter logic [63:0] REGOUTPUT = MODE_BYPASS,
  parameter bit          SIGNED    = 1'b0
) (
  input wire logic             CLK,
  input wire logic             RST,
  nexus_mult9x9_pipe_if.slave  bus
);

  localparam bit c_REG_A  = (REGINPUTA == MODE_REGISTER);
  localparam bit c_REG_B  = (REGINPUTB == MODE_REGISTER);
  localparam bit c_REG_Z  = (REGOUTPUT == MODE_REGISTER);
  localparam bit c_IN_STG = c_REG_A || c_REG_B;

  logic [MULT_A_W-1:0] w_aq;
  logic [MULT_B_W-1:0] w_bq;
  logic                w_vin;
  logic                w_in_en;
  logic [MULT_Z_W-1:0] w_prod;

  // The input valid only advances when every present operand register loads.
  assign w_in_en = (!c_REG_A || bus.CEA) && (!c_REG_B || bus.CEB);

  nexus_mult_stage #(.W(MULT_A_W), .BYPASS(!c_REG_A)) u_stg_a (
    .CLK(CLK), .RST(RST), .i_en(bus.CEA), .i_d(bus.A), .o_q(w_aq)
  );

  nexus_mult_stage #(.W(MULT_B_W), .BYPASS(!c_REG_B)) u_stg_b (
    .CLK(CLK), .RST(RST), .i_en(bus.CEB), .i_d(bus.B), .o_q(w_bq)
  );

  nexus_mult_stage #(.W(1), .BYPASS(!c_IN_STG)) u_stg_vin (
    .CLK(CLK), .RST(RST), .i_en(w_in_en), .i_d(bus.VLD_I), .o_q(w_vin)
  );

  // Low 18 bits of the 18x18 product of extended operands is exact for 9x9.
  assign w_prod = ext_operand(w_aq, SIGNED) * ext_operand(w_bq, SIGNED);

  nexus_mult_stage #(.W(MULT_Z_W), .BYPASS(!c_REG_Z)) u_stg_z (
    .CLK(CLK), .RST(RST), .i_en(bus.CEOUT), .i_d(w_prod), .o_q(bus.Z)
  );

  nexus_mult_stage #(.W(1), .BYPASS(!c_REG_Z)) u_stg_vout (
    .CLK(CLK), .RST(RST), .i_en(bus.CEOUT), .i_d(w_vin), .o_q(bus.VLD_O)
  );

`ifdef NEXUS_MULT_TAP_EN
  assign bus.AQ = w_aq;
  assign bus.BQ = w_bq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nexus_mult9x9_pipe.sv
`default_nettype none
// Scoreboard bench: four configurations share one stimulus stream; expected
// products are queued with their due cycle and popped by a negedge monitor.
module tb_nexus_mult9x9_pipe;
  import nexus_mult_pkg::*;

  typedef struct {
    logic [17:0] z;
    int          due;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  nexus_mult9x9_pipe_if if0 ();
  nexus_mult9x9_pipe_if if1 ();
  nexus_mult9x9_pipe_if if2 ();
  nexus_mult9x9_pipe_if if3 ();

  nexus_mult9x9_pipe #(.REGINPUTA("BYPASS"), .REGINPUTB("BYPASS"),
                       .REGOUTPUT("BYPASS"), .SIGNED(1'b0))
    u_byp (.CLK(CLK), .RST(RST), .bus(if0));
  nexus_mult9x9_pipe #(.REGINPUTA("REGISTER"), .REGINPUTB("REGISTER"),
                       .REGOUTPUT("REGISTER"), .SIGNED(1'b1))
    u_full (.CLK(CLK), .RST(RST), .bus(if1));
  nexus_mult9x9_pipe #(.REGINPUTA("BYPASS"), .REGINPUTB("BYPASS"),
                       .REGOUTPUT("REGISTER"), .SIGNED(1'b0))
    u_outo (.CLK(CLK), .RST(RST), .bus(if2));
  nexus_mult9x9_pipe #(.REGINPUTA("REGISTER"), .REGINPUTB("BYPASS"),
                       .REGOUTPUT("BYPASS"), .SIGNED(1'b0))
    u_mixa (.CLK(CLK), .RST(RST), .bus(if3));

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc   = 0;
  exp_t       sb[4][$];
  logic       ceout_q;
  logic       mix_pv = 1'b0;
  logic [8:0] mix_pa = 9'd0;

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    ceout_q <= if2.CEOUT;
  end

  function automatic logic [17:0] ref_mul(input logic [8:0] a, input logic [8:0] b,
                                          input bit sgn);
    int ia, ib, p;
    ia = sgn ? int'($signed(a)) : int'(a);
    ib = sgn ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    return p[17:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic vld, input logic [17:0] z);
    exp_t e;
    if (vld !== 1'b1) return;
    n_chk++;
    if (sb[k].size() == 0) begin
      n_err++;
      $display("FAIL sb%0d unexpected output: z=%0h at cycle %0d, none expected", k, z, cyc);
    end else begin
      e = sb[k].pop_front();
      if (z !== e.z || cyc != e.due) begin
        n_err++;
        $display("FAIL sb%0d: got z=%0h at cycle %0d expected z=%0h at cycle %0d",
                 k, z, cyc, e.z, e.due);
      end
    end
  endtask

  always @(negedge CLK) begin
    mon(0, if0.VLD_O, if0.Z);
    mon(1, if1.VLD_O, if1.Z);
    if (ceout_q === 1'b1) mon(2, if2.VLD_O, if2.Z);
    mon(3, if3.VLD_O, if3.Z);
  end

  // One clock of stimulus for all four DUTs; expectations follow from the
  // configured latency of each (0, 2, 1 and mixed A-delayed/B-direct).
  task automatic step(input logic [8:0] a, input logic [8:0] b, input logic v,
                      input logic ceo);
    @(posedge CLK);
    #1;
`ifdef NEXUS_MULT_TAP_EN
    chk("aq_reg", 32'(if3.AQ), 32'(mix_pa));
`endif
    if0.A = a; if0.B = b; if0.VLD_I = v;
    if1.A = a; if1.B = b; if1.VLD_I = v;
    if2.A = a; if2.B = b; if2.VLD_I = v; if2.CEOUT = ceo;
    if3.A = a; if3.B = b; if3.VLD_I = v;
    if (v) begin
      sb[0].push_back('{ref_mul(a, b, 1'b0), cyc});
      sb[1].push_back('{ref_mul(a, b, 1'b1), cyc + 2});
      if (ceo) sb[2].push_back('{ref_mul(a, b, 1'b0), cyc + 1});
    end
    if (mix_pv) sb[3].push_back('{ref_mul(mix_pa, b, 1'b0), cyc});
    mix_pv = v;
    mix_pa = a;
    #1;
`ifdef NEXUS_MULT_TAP_EN
    chk("aq_byp", 32'(if0.AQ), 32'(a));
    chk("bq_byp", 32'(if3.BQ), 32'(b));
`endif
  endtask

  initial begin
    if0.A = '0; if0.B = '0; if0.VLD_I = 1'b0; if0.CEA = 1'b1; if0.CEB = 1'b1; if0.CEOUT = 1'b1;
    if1.A = '0; if1.B = '0; if1.VLD_I = 1'b0; if1.CEA = 1'b1; if1.CEB = 1'b1; if1.CEOUT = 1'b1;
    if2.A = '0; if2.B = '0; if2.VLD_I = 1'b0; if2.CEA = 1'b1; if2.CEB = 1'b1; if2.CEOUT = 1'b1;
    if3.A = '0; if3.B = '0; if3.VLD_I = 1'b0; if3.CEA = 1'b1; if3.CEB = 1'b1; if3.CEOUT = 1'b1;

    // Reset state; the all-bypass instance ignores RST.
    repeat (2) @(posedge CLK);
    #2;
    if0.A = 9'd5; if0.B = 9'd6;
    #1;
    chk("rst_byp_z", 32'(if0.Z), 32'd30);
    chk("rst_full_z", 32'(if1.Z), 32'd0);
    chk("rst_full_vld", 32'(if1.VLD_O), 32'd0);
    chk("rst_outo_z", 32'(if2.Z), 32'd0);
    chk("rst_outo_vld", 32'(if2.VLD_O), 32'd0);
    chk("rst_mix_z", 32'(if3.Z), 32'd0);
    chk("rst_mix_vld", 32'(if3.VLD_O), 32'd0);
    if0.A = '0; if0.B = '0;
    @(posedge CLK);
    #2 RST = 1'b0;

    // All-bypass same-cycle product.
    step(9'd511, 9'd2, 1'b1, 1'b1);
    chk("byp_511x2", 32'(if0.Z), 32'h003FE);
    chk("byp_vld", 32'(if0.VLD_O), 32'd1);

    // Signed -1*2, then a back-to-back stream.
    step(9'h1FF, 9'd2, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) step(9'(i), 9'd3, 1'b1, 1'b1);
    repeat (3) step(9'd0, 9'd0, 1'b0, 1'b1);

    // Mixed mode: registered A from one cycle, bypassed B from the next.
    step(9'd3, 9'd0, 1'b1, 1'b1);
    step(9'd0, 9'd4, 1'b0, 1'b1);
    chk("mix_3x4", 32'(if3.Z), 32'd12);
    chk("mix_vld", 32'(if3.VLD_O), 32'd1);
    step(9'd0, 9'd0, 1'b0, 1'b1);

    // Output-register stall: CEOUT low for three edges.
    step(9'd7, 9'd3, 1'b1, 1'b1);
    step(9'd10, 9'd10, 1'b1, 1'b0);
    step(9'd10, 9'd10, 1'b1, 1'b0);
    chk("stall_hold1", 32'(if2.Z), 32'd21);
    step(9'd10, 9'd10, 1'b1, 1'b0);
    chk("stall_hold2", 32'(if2.Z), 32'd21);
    step(9'd10, 9'd10, 1'b1, 1'b1);
    chk("stall_hold3", 32'(if2.Z), 32'd21);
    step(9'd0, 9'd0, 1'b0, 1'b1);
    chk("stall_release_z", 32'(if2.Z), 32'd100);
    chk("stall_release_vld", 32'(if2.VLD_O), 32'd1);
    repeat (2) step(9'd0, 9'd0, 1'b0, 1'b1);

    // Reset mid-cycle with two samples inside the full pipeline.
    step(9'd20, 9'd30, 1'b1, 1'b1);
    step(9'd40, 9'd50, 1'b1, 1'b1);
    step(9'd0, 9'd0, 1'b0, 1'b1);
    #1 RST = 1'b1;
    #1;
    chk("midrst_full_z", 32'(if1.Z), 32'd0);
    chk("midrst_full_vld", 32'(if1.VLD_O), 32'd0);
    chk("midrst_outo_vld", 32'(if2.VLD_O), 32'd0);
    sb[1].delete(); sb[2].delete(); sb[3].delete();
    mix_pv = 1'b0;
    mix_pa = 9'd0;
    @(posedge CLK);
    #2 RST = 1'b0;
    step(9'd6, 9'd7, 1'b1, 1'b1);
    repeat (3) step(9'd0, 9'd0, 1'b0, 1'b1);

    // Randomised traffic with occasional output-register stalls.
    repeat (300)
      step(9'($urandom), 9'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    repeat (4) step(9'd0, 9'd0, 1'b0, 1'b1);

    for (int k = 0; k < 4; k++) chk($sformatf("sb%0d_drained", k), 32'(sb[k].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
